// File: rtl/i2c_target_regs_if.sv
// Bus bundle for the I2C target register window: oversampled SCL/SDA pins,
// the open-drain SDA pull-down request and the user-side register strobes.
interface i2c_target_regs_if;
    logic       scl_i;
    logic       sda_i;
    logic       sda_oe;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;
    logic       busy;

    // The target side: samples the pins and the user read data.
    modport slave (
        input  scl_i, sda_i, reg_rdata,
        output sda_oe, reg_addr, reg_wdata, reg_we, reg_re, busy
    );

    // The environment side: bus master plus user register logic.
    modport master (
        output scl_i, sda_i, reg_rdata,
        input  sda_oe, reg_addr, reg_wdata, reg_we, reg_re, busy
    );
endinterface

// File: rtl/i2c_target_regs.sv
// I2C target answering at a 7-bit address. The first written byte sets a
// register pointer, further written bytes produce reg_we strobes, and reads
// fetch bytes through reg_re / reg_rdata. The pointer auto-increments per byte.
module i2c_target_regs #(
    parameter logic [6:0] ADDRESS     = 7'h25,
    parameter int         SYNC_STAGES = 3
) (
    input  logic             clk48,
    input  logic             reset_n,
    i2c_target_regs_if.slave bus
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        ADDR     = 4'd1,
        ADDR_ACK = 4'd2,
        PTR      = 4'd3,
        WR_DATA  = 4'd4,
        WR_ACK   = 4'd5,
        RD_LOAD  = 4'd6,
        RD_DATA  = 4'd7,
        RD_ACK   = 4'd8,
        IGNORE   = 4'd9
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_prev_q, sda_prev_q;
    logic                   scl_s, sda_s;
    logic                   start_det, stop_det, scl_rise, scl_fall;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       sda_oe_q, sda_oe_d;
    logic [7:0] reg_addr_q, reg_addr_d;
    logic [7:0] reg_wdata_q, reg_wdata_d;
    logic       reg_we_q, reg_we_d;
    logic       reg_re_q, reg_re_d;
    logic       busy_q, busy_d;
    logic       re_dly_q;

    // Synchronise the pins (idle-high reset values) and keep one older sample for edges
    always_ff @(posedge clk48 or negedge reset_n) begin
        if (!reset_n) begin
            scl_sync_q <= {SYNC_STAGES{1'b1}};
            sda_sync_q <= {SYNC_STAGES{1'b1}};
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], bus.scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], bus.sda_i};
            scl_prev_q <= scl_sync_q[SYNC_STAGES-1];
            sda_prev_q <= sda_sync_q[SYNC_STAGES-1];
        end
    end

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;

    // State and output registers; reset clears everything immediately, even mid-byte
    always_ff @(posedge clk48 or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            shift_q     <= 8'h00;
            sda_oe_q    <= 1'b0;
            reg_addr_q  <= 8'h00;
            reg_wdata_q <= 8'h00;
            reg_we_q    <= 1'b0;
            reg_re_q    <= 1'b0;
            busy_q      <= 1'b0;
            re_dly_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            sda_oe_q    <= sda_oe_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_we_q    <= reg_we_d;
            reg_re_q    <= reg_re_d;
            busy_q      <= busy_d;
            re_dly_q    <= reg_re_q;
        end
    end

    // Next-state logic; START/STOP win over any bit activity in the same cycle
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        sda_oe_d    = sda_oe_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_we_d    = 1'b0;
        reg_re_d    = 1'b0;
        busy_d      = busy_q;
        if (start_det) begin
            state_d  = ADDR;
            cnt_d    = 4'd0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (stop_det) begin
            state_d  = IDLE;
            cnt_d    = 4'd0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                ADDR: begin
                    if (scl_rise && (cnt_q < 4'd8)) begin
                        shift_d = {shift_q[6:0], sda_s};
                        cnt_d   = cnt_q + 4'd1;
                    end else if (scl_fall && (cnt_q == 4'd8)) begin
                        cnt_d = 4'd0;
                        if (shift_q[7:1] == ADDRESS) begin
                            state_d  = ADDR_ACK;
                            sda_oe_d = 1'b1;
                            busy_d   = 1'b1;
                        end else begin
                            state_d = IGNORE;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                ADDR_ACK: begin
                    // shift_q[0] still holds the R/W bit of the address byte
                    if (scl_fall && shift_q[0]) begin
                        reg_re_d = 1'b1;
                        state_d  = RD_LOAD;
                    end else if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        cnt_d    = 4'd0;
                        state_d  = PTR;
                    end else begin
                        state_d = state_q;
                    end
                end
                PTR: begin
                    // cnt 0..8 = data bits, 9 = our ACK clock in progress
                    if (scl_rise && (cnt_q < 4'd8)) begin
                        shift_d = {shift_q[6:0], sda_s};
                        cnt_d   = cnt_q + 4'd1;
                    end else if (scl_fall && (cnt_q == 4'd8)) begin
                        reg_addr_d = shift_q;
                        sda_oe_d   = 1'b1;
                        cnt_d      = 4'd9;
                    end else if (scl_fall && (cnt_q == 4'd9)) begin
                        sda_oe_d = 1'b0;
                        cnt_d    = 4'd0;
                        state_d  = WR_DATA;
                    end else begin
                        state_d = state_q;
                    end
                end
                WR_DATA: begin
                    if (scl_rise && (cnt_q < 4'd8)) begin
                        shift_d = {shift_q[6:0], sda_s};
                        cnt_d   = cnt_q + 4'd1;
                    end else if (scl_fall && (cnt_q == 4'd8)) begin
                        reg_wdata_d = shift_q;
                        reg_we_d    = 1'b1;
                        sda_oe_d    = 1'b1;
                        state_d     = WR_ACK;
                    end else begin
                        state_d = state_q;
                    end
                end
                WR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d   = 1'b0;
                        reg_addr_d = reg_addr_q + 8'd1;
                        cnt_d      = 4'd0;
                        state_d    = WR_DATA;
                    end else begin
                        state_d = state_q;
                    end
                end
                RD_LOAD: begin
                    // reg_rdata is valid the cycle after the reg_re pulse
                    if (re_dly_q) begin
                        shift_d  = bus.reg_rdata;
                        sda_oe_d = ~bus.reg_rdata[7];
                        cnt_d    = 4'd0;
                        state_d  = RD_DATA;
                    end else begin
                        state_d = state_q;
                    end
                end
                RD_DATA: begin
                    if (scl_fall && (cnt_q == 4'd7)) begin
                        sda_oe_d = 1'b0;
                        cnt_d    = 4'd8;
                        state_d  = RD_ACK;
                    end else if (scl_fall) begin
                        shift_d  = {shift_q[6:0], 1'b0};
                        sda_oe_d = ~shift_q[6];
                        cnt_d    = cnt_q + 4'd1;
                    end else begin
                        state_d = state_q;
                    end
                end
                RD_ACK: begin
                    // cnt 8 = waiting for master ACK bit, 9 = ACK seen, fetch on the fall
                    if (scl_rise && (cnt_q == 4'd8)) begin
                        reg_addr_d = reg_addr_q + 8'd1;
                        if (sda_s) begin
                            state_d = IGNORE;
                        end else begin
                            cnt_d = 4'd9;
                        end
                    end else if (scl_fall && (cnt_q == 4'd9)) begin
                        reg_re_d = 1'b1;
                        state_d  = RD_LOAD;
                    end else begin
                        state_d = state_q;
                    end
                end
                IDLE:    state_d = IDLE;
                IGNORE:  state_d = IGNORE;
                default: begin
                    state_d  = IDLE;
                    sda_oe_d = 1'b0;
                    busy_d   = 1'b0;
                end
            endcase
        end
    end

    assign bus.sda_oe    = sda_oe_q;
    assign bus.reg_addr  = reg_addr_q;
    assign bus.reg_wdata = reg_wdata_q;
    assign bus.reg_we    = reg_we_q;
    assign bus.reg_re    = reg_re_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench for i2c_target_regs: a bit-banged I2C master, an
// open-drain SDA model and a user register block returning addr ^ 0xFF.
module tb_i2c_target_regs;

    logic clk48   = 1'b0;
    logic reset_n = 1'b0;
    logic m_scl   = 1'b1;
    logic m_sda   = 1'b1;
    logic [7:0] user_rdata;

    int errors   = 0;
    int checks   = 0;
    int oe_cnt   = 0;
    int busy_cnt = 0;
    int both_cnt = 0;
    logic [7:0] we_addr[$];
    logic [7:0] we_data[$];
    logic [7:0] re_addr[$];

    i2c_target_regs_if ifc();

    i2c_target_regs #(.ADDRESS(7'h25), .SYNC_STAGES(3)) dut (
        .clk48   (clk48),
        .reset_n (reset_n),
        .bus     (ifc)
    );

    always #10 clk48 = ~clk48;

    assign ifc.scl_i     = m_scl;
    assign ifc.sda_i     = m_sda & ~ifc.sda_oe;
    assign ifc.reg_rdata = user_rdata;

    // User register block: read data appears the cycle after reg_re
    always @(posedge clk48 or negedge reset_n) begin
        if (!reset_n) user_rdata <= 8'h00;
        else if (ifc.reg_re) user_rdata <= ifc.reg_addr ^ 8'hFF;
    end

    // Strobe and level monitor, sampled away from the active edge
    always @(negedge clk48) begin
        if (ifc.reg_we) begin
            we_addr.push_back(ifc.reg_addr);
            we_data.push_back(ifc.reg_wdata);
        end
        if (ifc.reg_re) re_addr.push_back(ifc.reg_addr);
        if (ifc.sda_oe) oe_cnt++;
        if (ifc.busy) busy_cnt++;
        if (ifc.reg_we && ifc.reg_re) both_cnt++;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk48);
    endtask

    task automatic send_start;
        m_sda = 1'b0; cyc(20);
        m_scl = 1'b0; cyc(20);
    endtask

    task automatic send_rstart;
        cyc(5); m_sda = 1'b1; cyc(15);
        m_scl = 1'b1; cyc(20);
        m_sda = 1'b0; cyc(20);
        m_scl = 1'b0; cyc(20);
    endtask

    task automatic send_stop;
        cyc(5); m_sda = 1'b0; cyc(15);
        m_scl = 1'b1; cyc(20);
        m_sda = 1'b1; cyc(20);
    endtask

    task automatic write_bit(input logic b);
        cyc(5); m_sda = b; cyc(15);
        m_scl = 1'b1; cyc(20);
        m_scl = 1'b0;
    endtask

    task automatic get_ack(output logic a);
        cyc(5); m_sda = 1'b1; cyc(15);
        m_scl = 1'b1; cyc(10);
        @(negedge clk48); a = ifc.sda_i;
        cyc(10);
        m_scl = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic a);
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        get_ack(a);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] b);
        cyc(5); m_sda = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            cyc(20);
            m_scl = 1'b1; cyc(10);
            @(negedge clk48); b[i] = ifc.sda_i;
            cyc(10);
            m_scl = 1'b0;
        end
        write_bit(mack);
    endtask

    task automatic test_reset;
        @(negedge clk48);
        checks++; if (ifc.sda_oe !== 1'b0) begin errors++; $display("FAIL reset_sda_oe got=%b exp=0", ifc.sda_oe); end
        checks++; if (ifc.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", ifc.busy); end
        checks++; if (ifc.reg_addr !== 8'h00) begin errors++; $display("FAIL reset_reg_addr got=%h exp=00", ifc.reg_addr); end
        checks++; if (ifc.reg_wdata !== 8'h00) begin errors++; $display("FAIL reset_reg_wdata got=%h exp=00", ifc.reg_wdata); end
        checks++; if ({ifc.reg_we, ifc.reg_re} !== 2'b00) begin errors++; $display("FAIL reset_strobes got=%b exp=00", {ifc.reg_we, ifc.reg_re}); end
        reset_n = 1'b1;
        cyc(20);
    endtask

    task automatic test_write_basic;
        int   b0;
        logic a;
        logic [7:0] vals [4];
        vals[0] = 8'h4A; vals[1] = 8'h10; vals[2] = 8'hAB; vals[3] = 8'hCD;
        b0 = we_addr.size();
        send_start;
        for (int i = 0; i < 4; i++) begin
            write_byte(vals[i], a);
            checks++; if (a !== 1'b0) begin errors++; $display("FAIL wr_ack byte%0d got=%b exp=0", i, a); end
        end
        @(negedge clk48);
        checks++; if (ifc.busy !== 1'b1) begin errors++; $display("FAIL wr_busy_before_stop got=%b exp=1", ifc.busy); end
        send_stop;
        @(negedge clk48);
        checks++; if (ifc.busy !== 1'b0) begin errors++; $display("FAIL wr_busy_after_stop got=%b exp=0", ifc.busy); end
        checks++; if (ifc.reg_addr !== 8'h12) begin errors++; $display("FAIL wr_final_addr got=%h exp=12", ifc.reg_addr); end
        checks++; if (we_addr.size() !== b0 + 2) begin errors++; $display("FAIL wr_we_count got=%0d exp=%0d", we_addr.size() - b0, 2); end
        if (we_addr.size() >= b0 + 2) begin
            checks++; if ({we_addr[b0], we_data[b0]} !== 16'h10AB) begin errors++; $display("FAIL wr_we0 got=%h/%h exp=10/AB", we_addr[b0], we_data[b0]); end
            checks++; if ({we_addr[b0+1], we_data[b0+1]} !== 16'h11CD) begin errors++; $display("FAIL wr_we1 got=%h/%h exp=11/CD", we_addr[b0+1], we_data[b0+1]); end
        end
    endtask

    task automatic test_read;
        int   r0;
        logic a;
        logic [7:0] d;
        r0 = re_addr.size();
        send_start;
        write_byte(8'h4A, a);
        write_byte(8'h10, a);
        send_rstart;
        write_byte(8'h4B, a);
        checks++; if (a !== 1'b0) begin errors++; $display("FAIL rd_addr_ack got=%b exp=0", a); end
        read_byte(1'b0, d);
        checks++; if (d !== 8'hEF) begin errors++; $display("FAIL rd_byte0 got=%h exp=EF", d); end
        read_byte(1'b1, d);
        checks++; if (d !== 8'hEE) begin errors++; $display("FAIL rd_byte1 got=%h exp=EE", d); end
        send_stop;
        @(negedge clk48);
        checks++; if (re_addr.size() !== r0 + 2) begin errors++; $display("FAIL rd_re_count got=%0d exp=2", re_addr.size() - r0); end
        if (re_addr.size() >= r0 + 2) begin
            checks++; if ({re_addr[r0], re_addr[r0+1]} !== 16'h1011) begin errors++; $display("FAIL rd_re_addrs got=%h,%h exp=10,11", re_addr[r0], re_addr[r0+1]); end
        end
        checks++; if (ifc.reg_addr !== 8'h12) begin errors++; $display("FAIL rd_final_addr got=%h exp=12", ifc.reg_addr); end
        checks++; if (both_cnt !== 0) begin errors++; $display("FAIL rd_we_re_overlap got=%0d exp=0", both_cnt); end
    endtask

    task automatic test_wrong_address;
        int   oe0, we0, busy0;
        logic a;
        oe0 = oe_cnt; we0 = we_addr.size(); busy0 = busy_cnt;
        send_start;
        write_byte(8'h4C, a);
        checks++; if (a !== 1'b1) begin errors++; $display("FAIL miss_addr_nack got=%b exp=1", a); end
        write_byte(8'h01, a);
        write_byte(8'h02, a);
        checks++; if (a !== 1'b1) begin errors++; $display("FAIL miss_data_nack got=%b exp=1", a); end
        send_stop;
        @(negedge clk48);
        checks++; if (oe_cnt !== oe0) begin errors++; $display("FAIL miss_sda_oe cycles got=%0d exp=0", oe_cnt - oe0); end
        checks++; if (we_addr.size() !== we0) begin errors++; $display("FAIL miss_we count got=%0d exp=0", we_addr.size() - we0); end
        checks++; if (busy_cnt !== busy0) begin errors++; $display("FAIL miss_busy cycles got=%0d exp=0", busy_cnt - busy0); end
    endtask

    task automatic test_pointer_wrap;
        int   b0;
        logic a;
        b0 = we_addr.size();
        send_start;
        write_byte(8'h4A, a);
        write_byte(8'hFF, a);
        write_byte(8'h11, a);
        write_byte(8'h22, a);
        checks++; if (a !== 1'b0) begin errors++; $display("FAIL wrap_ack got=%b exp=0", a); end
        send_stop;
        @(negedge clk48);
        checks++; if (we_addr.size() !== b0 + 2) begin errors++; $display("FAIL wrap_we_count got=%0d exp=2", we_addr.size() - b0); end
        if (we_addr.size() >= b0 + 2) begin
            checks++; if ({we_addr[b0], we_data[b0]} !== 16'hFF11) begin errors++; $display("FAIL wrap_we0 got=%h/%h exp=FF/11", we_addr[b0], we_data[b0]); end
            checks++; if ({we_addr[b0+1], we_data[b0+1]} !== 16'h0022) begin errors++; $display("FAIL wrap_we1 got=%h/%h exp=00/22", we_addr[b0+1], we_data[b0+1]); end
        end
        checks++; if (ifc.reg_addr !== 8'h01) begin errors++; $display("FAIL wrap_final_addr got=%h exp=01", ifc.reg_addr); end
    endtask

    task automatic test_reset_mid_read;
        logic a;
        send_start;
        write_byte(8'h4A, a);
        write_byte(8'h80, a);
        send_rstart;
        write_byte(8'h4B, a);
        cyc(20);
        @(negedge clk48);
        // 0x80 ^ 0xFF = 0x7F, so the first read bit is 0 and SDA is pulled
        checks++; if (ifc.sda_oe !== 1'b1) begin errors++; $display("FAIL rst_pre_sda_oe got=%b exp=1", ifc.sda_oe); end
        reset_n = 1'b0;
        #1;
        checks++; if (ifc.sda_oe !== 1'b0) begin errors++; $display("FAIL rst_sda_oe got=%b exp=0", ifc.sda_oe); end
        checks++; if (ifc.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", ifc.busy); end
        checks++; if (ifc.reg_addr !== 8'h00) begin errors++; $display("FAIL rst_reg_addr got=%h exp=00", ifc.reg_addr); end
        m_scl = 1'b1; m_sda = 1'b1;
        cyc(5);
        reset_n = 1'b1;
        cyc(20);
        test_write_basic;
    endtask

    task automatic test_stop_mid_byte;
        int   b0;
        logic a;
        b0 = we_addr.size();
        send_start;
        write_byte(8'h4A, a);
        write_byte(8'h20, a);
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
        send_stop;
        @(negedge clk48);
        checks++; if (we_addr.size() !== b0) begin errors++; $display("FAIL stop_we count got=%0d exp=0", we_addr.size() - b0); end
        checks++; if (ifc.sda_oe !== 1'b0) begin errors++; $display("FAIL stop_sda_oe got=%b exp=0", ifc.sda_oe); end
        checks++; if (ifc.busy !== 1'b0) begin errors++; $display("FAIL stop_busy got=%b exp=0", ifc.busy); end
        checks++; if (ifc.reg_addr !== 8'h20) begin errors++; $display("FAIL stop_reg_addr got=%h exp=20", ifc.reg_addr); end
        // Idle target must not respond to bytes clocked without a START
        m_scl = 1'b0; cyc(20);
        write_byte(8'h4A, a);
        checks++; if (a !== 1'b1) begin errors++; $display("FAIL stop_idle_nack got=%b exp=1", a); end
        send_stop;
    endtask

    initial begin
        cyc(5);
        test_reset;
        test_write_basic;
        test_read;
        test_wrong_address;
        test_pointer_wrap;
        test_reset_mid_read;
        test_stop_mid_byte;
        checks++; if (both_cnt !== 0) begin errors++; $display("FAIL we_re_overlap got=%0d exp=0", both_cnt); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
